// File: rtl/elm_sequencer.sv
// rtl/elm_sequencer.sv - frame sequencer for the ELM classifier datapath
// Walks IDLE -> CLEAR -> RUN -> REPORT, with a watchdog and one-hot result encoding.
module elm_sequencer #(
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 200000,
    parameter int EXP_BLOCKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    output logic       frame_ack,
    output logic       dp_rst,
    output logic       dp_start,
    input  logic       dp_done256,
    input  logic       dp_over,
    input  logic [9:0] dp_digit,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_digit,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] blk_cnt
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, REPORT} state_t;

    state_t      state, state_n;
    logic [3:0]  clr_cnt, clr_cnt_n;
    logic [19:0] wdog, wdog_n;
    logic        frame_ack_n, dp_rst_n, dp_start_n, res_valid_n, res_err_n, busy_n;
    logic [3:0]  res_digit_n;
    logic [7:0]  blk_cnt_n, blk_next;
    logic [3:0]  ones, idx;
    logic        onehot;
    logic [3:0]  enc;

    always_comb begin
        ones = 4'd0;
        idx  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (dp_digit[i]) begin
                ones = ones + 4'd1;
                idx  = 4'(i);
            end
        end
        onehot = (ones == 4'd1);
        enc    = onehot ? idx : 4'hF;
    end

    // The pulse arriving with dp_over must be part of the final count check.
    assign blk_next = (dp_done256 && blk_cnt != 8'hFF) ? blk_cnt + 8'd1 : blk_cnt;

    always_comb begin
        state_n     = state;
        clr_cnt_n   = clr_cnt;
        wdog_n      = wdog;
        frame_ack_n = 1'b0;
        dp_rst_n    = dp_rst;
        dp_start_n  = dp_start;
        res_valid_n = res_valid;
        res_digit_n = res_digit;
        res_err_n   = res_err;
        blk_cnt_n   = blk_cnt;
        case (state)
            IDLE: begin
                dp_rst_n   = 1'b0;
                dp_start_n = 1'b0;
                if (frame_req) begin
                    state_n     = CLEAR;
                    frame_ack_n = 1'b1;
                    dp_rst_n    = 1'b1;
                    clr_cnt_n   = 4'd1;
                    blk_cnt_n   = 8'd0;
                    wdog_n      = 20'd0;
                    res_valid_n = 1'b0;
                end
            end
            CLEAR: begin
                if (clr_cnt == 4'(CLR_CYCLES)) begin
                    state_n    = RUN;
                    dp_rst_n   = 1'b0;
                    dp_start_n = 1'b1;
                end else begin
                    clr_cnt_n = clr_cnt + 4'd1;
                end
            end
            RUN: begin
                blk_cnt_n = blk_next;
                if (dp_over) begin
                    state_n     = REPORT;
                    dp_start_n  = 1'b0;
                    res_valid_n = 1'b1;
                    res_digit_n = enc;
                    res_err_n   = !onehot || (blk_next != 8'(EXP_BLOCKS));
                end else if (wdog == 20'(TIMEOUT - 1)) begin
                    state_n     = REPORT;
                    dp_start_n  = 1'b0;
                    res_valid_n = 1'b1;
                    res_digit_n = 4'hF;
                    res_err_n   = 1'b1;
                end else begin
                    wdog_n = wdog + 20'd1;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_n     = IDLE;
                    res_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clr_cnt   <= 4'd0;
            wdog      <= 20'd0;
            frame_ack <= 1'b0;
            dp_rst    <= 1'b0;
            dp_start  <= 1'b0;
            res_valid <= 1'b0;
            res_digit <= 4'd0;
            res_err   <= 1'b0;
            busy      <= 1'b0;
            blk_cnt   <= 8'd0;
        end else begin
            state     <= state_n;
            clr_cnt   <= clr_cnt_n;
            wdog      <= wdog_n;
            frame_ack <= frame_ack_n;
            dp_rst    <= dp_rst_n;
            dp_start  <= dp_start_n;
            res_valid <= res_valid_n;
            res_digit <= res_digit_n;
            res_err   <= res_err_n;
            busy      <= busy_n;
            blk_cnt   <= blk_cnt_n;
        end
    end

endmodule

// File: tb/tb_elm_sequencer.sv
// tb/tb_elm_sequencer.sv - randomized self-checking bench for elm_sequencer
// A short-timeout instance carries most scenarios; a long-timeout twin covers saturation.
module tb_elm_sequencer;

    localparam int CLR  = 2;
    localparam int TO   = 100;
    localparam int TO_S = 400;
    localparam int EXP  = 16;

    logic       clk = 1'b0;
    logic       rst, frame_req, dp_done256, dp_over, res_ready;
    logic [9:0] dp_digit;
    logic       frame_ack, dp_rst, dp_start, res_valid, res_err, busy;
    logic [3:0] res_digit;
    logic [7:0] blk_cnt;
    logic       frame_ack_s, dp_rst_s, dp_start_s, res_valid_s, res_err_s, busy_s;
    logic [3:0] res_digit_s;
    logic [7:0] blk_cnt_s;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    elm_sequencer #(.CLR_CYCLES(CLR), .TIMEOUT(TO), .EXP_BLOCKS(EXP)) dut (
        .clk(clk), .rst(rst), .frame_req(frame_req), .frame_ack(frame_ack),
        .dp_rst(dp_rst), .dp_start(dp_start), .dp_done256(dp_done256),
        .dp_over(dp_over), .dp_digit(dp_digit), .res_valid(res_valid),
        .res_ready(res_ready), .res_digit(res_digit), .res_err(res_err),
        .busy(busy), .blk_cnt(blk_cnt)
    );

    elm_sequencer #(.CLR_CYCLES(CLR), .TIMEOUT(TO_S), .EXP_BLOCKS(EXP)) dut_sat (
        .clk(clk), .rst(rst), .frame_req(frame_req), .frame_ack(frame_ack_s),
        .dp_rst(dp_rst_s), .dp_start(dp_start_s), .dp_done256(dp_done256),
        .dp_over(dp_over), .dp_digit(dp_digit), .res_valid(res_valid_s),
        .res_ready(res_ready), .res_digit(res_digit_s), .res_err(res_err_s),
        .busy(busy_s), .blk_cnt(blk_cnt_s)
    );

    function automatic int sat255(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Reference result {err, digit}: count set bits, check block total, timeout forces error.
    function automatic logic [4:0] model_result(input logic [9:0] d, input int blocks, input bit timed_out);
        int nset = 0;
        int pos = 0;
        for (int i = 0; i < 10; i++) if (d[i]) begin nset++; pos = i; end
        if (timed_out)  return 5'h1F;
        if (nset != 1)  return 5'h1F;
        return {(sat255(blocks) != EXP), 4'(pos)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; frame_req = 1'b1; dp_over = 1'b1; dp_done256 = 1'b1; res_ready = 1'b1;
        step();
        rst = 1'b0; frame_req = 1'b0; dp_over = 1'b0; dp_done256 = 1'b0; res_ready = 1'b0;
        dp_digit = 10'd0;
    endtask

    task automatic run_frame(input string name, input int npulse, input logic [9:0] dig,
                             input int over_at, input int hold, input bit keep_req);
        int cnt = 0;
        int k = 0;
        bit done = 0;
        bit to = 0;
        logic [4:0] exp_r;
        logic [4:0] got_r;
        frame_req = 1'b1;
        step();
        checks++;
        if ({frame_ack, dp_rst, dp_start, busy} !== 4'b1101)
            $display("FAIL %s ack: got %b want 1101", name, {frame_ack, dp_rst, dp_start, busy});
        else passes++;
        if (!keep_req) frame_req = 1'b0;
        for (int c = 1; c <= CLR; c++) begin
            dp_done256 = 1'b1; dp_over = 1'b1; dp_digit = 10'($urandom);
            step();
            checks++;
            if (c < CLR) begin
                if ({frame_ack, dp_rst, dp_start, busy, res_valid} !== 5'b01010)
                    $display("FAIL %s clear%0d: got %b want 01010", name, c, {frame_ack, dp_rst, dp_start, busy, res_valid});
                else passes++;
            end else begin
                if ({frame_ack, dp_rst, dp_start, busy, res_valid, blk_cnt} !== {5'b00110, 8'd0})
                    $display("FAIL %s run_entry: got %b want 00110_00000000", name, {frame_ack, dp_rst, dp_start, busy, res_valid, blk_cnt});
                else passes++;
            end
        end
        while (!done) begin
            dp_done256 = (k < npulse);
            dp_over    = (k == over_at);
            dp_digit   = (k == over_at) ? dig : 10'($urandom);
            res_ready  = 1'($urandom);
            if (k < npulse) cnt++;
            step();
            if (k == over_at) done = 1;
            else if (k == TO - 1) begin done = 1; to = 1; end
            if (!done) begin
                checks++;
                if ({dp_start, res_valid, dp_rst, frame_ack} !== 4'b1000 || blk_cnt !== 8'(sat255(cnt)))
                    $display("FAIL %s run%0d: got %b cnt %0d want 1000 cnt %0d", name, k,
                             {dp_start, res_valid, dp_rst, frame_ack}, blk_cnt, sat255(cnt));
                else passes++;
            end
            k++;
        end
        dp_done256 = 1'b0; dp_over = 1'b0; res_ready = 1'b0;
        exp_r = model_result(dig, cnt, to);
        got_r = {res_err, res_digit};
        checks++;
        if ({res_valid, dp_start, dp_rst, busy} !== 4'b1001 || got_r !== exp_r || blk_cnt !== 8'(sat255(cnt)))
            $display("FAIL %s report: got v/s/r/b %b res %h cnt %0d want 1001 res %h cnt %0d", name,
                     {res_valid, dp_start, dp_rst, busy}, got_r, blk_cnt, exp_r, sat255(cnt));
        else passes++;
        for (int h = 0; h < hold; h++) begin
            dp_digit = 10'($urandom); dp_over = 1'($urandom); dp_done256 = 1'($urandom);
            step();
            checks++;
            if ({res_valid, frame_ack, busy} !== 3'b101 || {res_err, res_digit} !== exp_r || blk_cnt !== 8'(sat255(cnt)))
                $display("FAIL %s hold%0d: got v/a/b %b res %h cnt %0d want 101 res %h", name, h,
                         {res_valid, frame_ack, busy}, {res_err, res_digit}, blk_cnt, exp_r);
            else passes++;
        end
        dp_over = 1'b0; dp_done256 = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if ({res_valid, busy, dp_start, dp_rst, frame_ack} !== 5'b00000)
            $display("FAIL %s accept: got %b want 00000", name, {res_valid, busy, dp_start, dp_rst, frame_ack});
        else passes++;
        if (keep_req) begin
            step();
            frame_req = 1'b0;
            checks++;
            if ({frame_ack, busy, dp_rst} !== 3'b111)
                $display("FAIL %s reack: got %b want 111", name, {frame_ack, busy, dp_rst});
            else passes++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({frame_ack, dp_rst, dp_start, res_valid, res_err, busy, res_digit, blk_cnt} !== 18'd0)
            $display("FAIL reset: got %b want 0", {frame_ack, dp_rst, dp_start, res_valid, res_err, busy, res_digit, blk_cnt});
        else passes++;
        checks++;
        if ({frame_ack_s, dp_rst_s, dp_start_s, res_valid_s, res_err_s, busy_s, res_digit_s, blk_cnt_s} !== 18'd0)
            $display("FAIL reset_sat: got %b want 0", {frame_ack_s, dp_rst_s, dp_start_s, res_valid_s, res_err_s, busy_s, res_digit_s, blk_cnt_s});
        else passes++;
    endtask

    task automatic test_nominal();
        logic [9:0] d;
        apply_reset();
        run_frame("nominal", 16, 10'b0000001000, 37, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d = 10'd1 << $urandom_range(9, 0);
            run_frame("nominal_rand", 16, d, $urandom_range(80, 15), $urandom_range(3, 0), 0);
        end
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 16, 10'b1000000000, 20, 0, 0);
        run_frame("b2b_b", 16, 10'b0000000001, 15, 0, 0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_frame("backpressure", 16, 10'd1 << $urandom_range(9, 0), 25, 10, 1);
        apply_reset();
    endtask

    task automatic test_bad_digit();
        run_frame("bad_two", 16, 10'b0000000011, 30, 1, 0);
        run_frame("bad_zero", 16, 10'b0000000000, 30, 1, 0);
    endtask

    task automatic test_timeout();
        run_frame("timeout", 16, 10'b0000010000, -1, 1, 0);
        run_frame("timeout_tie", 16, 10'd1 << $urandom_range(9, 0), TO - 1, 1, 0);
    endtask

    task automatic test_block_count();
        run_frame("blk15", 15, 10'b0001000000, 30, 0, 0);
        run_frame("blk_tie", 16, 10'b0000000100, 15, 0, 0);
    endtask

    task automatic test_saturation();
        apply_reset();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        for (int c = 1; c <= CLR; c++) step();
        for (int k = 0; k < 300; k++) begin
            dp_done256 = 1'b1;
            step();
            checks++;
            if (blk_cnt_s !== 8'(sat255(k + 1)))
                $display("FAIL sat%0d: got %0d want %0d", k, blk_cnt_s, sat255(k + 1));
            else passes++;
        end
        dp_done256 = 1'b0; dp_over = 1'b1; dp_digit = 10'b0000100000;
        step();
        dp_over = 1'b0;
        checks++;
        if ({res_valid_s, res_err_s, res_digit_s, blk_cnt_s} !== {2'b11, 4'd5, 8'd255})
            $display("FAIL sat_report: got %b want 11_0101_11111111", {res_valid_s, res_err_s, res_digit_s, blk_cnt_s});
        else passes++;
        apply_reset();
    endtask

    task automatic test_reset_mid_run();
        int n;
        apply_reset();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        n = $urandom_range(30, 5);
        for (int c = 0; c < CLR + n; c++) begin
            dp_done256 = 1'($urandom);
            step();
        end
        rst = 1'b1; frame_req = 1'b1; dp_over = 1'b1; dp_digit = 10'b0000000010;
        step();
        rst = 1'b0; frame_req = 1'b0; dp_over = 1'b0; dp_done256 = 1'b0;
        checks++;
        if ({dp_start, dp_rst, res_valid, busy, frame_ack, blk_cnt} !== 13'd0)
            $display("FAIL midrun_rst: got %b want 0", {dp_start, dp_rst, res_valid, busy, frame_ack, blk_cnt});
        else passes++;
        for (int c = 0; c < 3; c++) begin
            dp_over = 1'b1; res_ready = 1'b1;
            step();
            checks++;
            if ({res_valid, busy, frame_ack, dp_start} !== 4'b0000)
                $display("FAIL midrun_idle%0d: got %b want 0000", c, {res_valid, busy, frame_ack, dp_start});
            else passes++;
        end
        dp_over = 1'b0; res_ready = 1'b0;
        run_frame("after_rst", 16, 10'b0010000000, 40, 0, 0);
    endtask

    initial begin
        rst = 1'b0; frame_req = 1'b0; dp_done256 = 1'b0; dp_over = 1'b0;
        res_ready = 1'b0; dp_digit = 10'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_nominal();
        test_back_to_back();
        test_backpressure();
        test_bad_digit();
        test_timeout();
        test_block_count();
        test_saturation();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
